ifetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined ARM core. It produces the `InstrF` / `PCPlus8` pair consumed by the decode stage. It drives a request/ready instruction-memory port, buffers returned words in a small prefetch queue, honours decode `stall`, and redirects the PC on a taken branch or PC write from later stages.

---
 rtl/ifetch_unit.sv | 140 ++++++++++++++
 tb/tb_ifetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: drives the imem request/ready port, buffers returned words
// in a small prefetch queue and presents the head as InstrF/PCPlus8 to decode.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] BranchTarget,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrF,
   output logic [31:0] PCPlus8,
   output logic        validF,
   output logic [1:0]  dbg_state_o
);

   localparam int PW = (QDEPTH > 2) ? 2 : 1;
   localparam int CW = 3;
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
   localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     q_instr_q [QDEPTH];
   logic [31:0]     q_pc8_q   [QDEPTH];

   logic            enq;
   logic            deq;
   logic [CW-1:0]   count_after_enq;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PLAST) ? '0 : p + PW'(1);
   endfunction

   assign validF          = (count_q != '0);
   assign deq             = validF && !stall && !redirect;
   assign count_after_enq = count_q + CW'(1) - (deq ? CW'(1) : CW'(0));

   assign InstrF      = validF ? q_instr_q[head_q] : 32'h0;
   assign PCPlus8     = validF ? q_pc8_q[head_q]   : 32'h0;
   assign dbg_state_o = state_q;

   // DRAIN keeps presenting the killed request's address until memory answers it.
   assign imem_addr = (state_q == S_DRAIN) ? req_addr_q : pc_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      enq        = 1'b0;
      imem_req   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               pc_d    = BranchTarget;
               state_d = S_REQ;
            end else if (count_q < QFULL) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ready && !redirect) begin
               enq  = 1'b1;
               pc_d = pc_q + 32'd4;
               if (count_after_enq == QFULL) state_d = S_IDLE;
            end else if (imem_ready) begin
               pc_d = BranchTarget;
            end else if (redirect) begin
               pc_d       = BranchTarget;
               req_addr_d = pc_q;
               state_d    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            imem_req = 1'b1;
            if (redirect) pc_d = BranchTarget;
            if (imem_ready) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A redirect flushes every entry and outranks both enqueue and dequeue.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (redirect) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = ptr_inc(tail_q);
         if (deq) head_d = ptr_inc(head_q);
         count_d = count_q + (enq ? CW'(1) : CW'(0)) - (deq ? CW'(1) : CW'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= 32'h0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_instr_q[tail_q] <= imem_rdata;
         q_pc8_q[tail_q]   <= pc_q + 32'd8;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit (RESET_PC=0x100, QDEPTH=2); memory returns addr^0xA5A5A5A5.
module tb_ifetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5A5A5;
   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_DRAIN = 2'd2;
   localparam logic [31:0] TP_INSTR [6] = '{32'hA5A5A4A5, 32'hA5A5A4A1, 32'hA5A5A4AD,
                                            32'hA5A5A4A9, 32'hA5A5A4B5, 32'hA5A5A4B1};
   localparam logic [31:0] TP_PC8   [6] = '{32'h108, 32'h10C, 32'h110,
                                            32'h114, 32'h118, 32'h11C};

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] BranchTarget;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] InstrF;
   logic [31:0] PCPlus8;
   logic        validF;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   ifetch_unit #(.RESET_PC(32'h100), .QDEPTH(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .BranchTarget(BranchTarget), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrF(InstrF),
      .PCPlus8(PCPlus8), .validF(validF), .dbg_state_o(dbg_state)
   );

   assign imem_rdata = imem_addr ^ KEY;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if (dut.count_q > 3'd2) begin
            errors++;
            $display("FAIL overflow: got count %0d want <= 2", dut.count_q);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0: the last edge sampled reset high.
   task automatic do_reset();
      reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0; BranchTarget = 32'h0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", validF); end
      checks++; if (InstrF !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", InstrF); end
      checks++; if (PCPlus8 !== 32'h0) begin errors++; $display("FAIL rst_pc8: got %h want 0", PCPlus8); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
      imem_ready = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL first_addr: got %h want 100", imem_addr); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL first_valid: got %b want 0", validF); end
      tick();
      checks++; if (InstrF !== 32'hA5A5A4A5) begin errors++; $display("FAIL first_instr: got %h want a5a5a4a5", InstrF); end
      checks++; if (PCPlus8 !== 32'h108) begin errors++; $display("FAIL first_pc8: got %h want 108", PCPlus8); end
      checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL second_addr: got %h want 104", imem_addr); end
   endtask

   task automatic test_throughput();
      do_reset();
      imem_ready = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (validF !== 1'b1) begin errors++; $display("FAIL tp_valid[%0d]: got %b want 1", k, validF); end
         checks++; if (InstrF !== TP_INSTR[k]) begin errors++; $display("FAIL tp_instr[%0d]: got %h want %h", k, InstrF, TP_INSTR[k]); end
         checks++; if (PCPlus8 !== TP_PC8[k]) begin errors++; $display("FAIL tp_pc8[%0d]: got %h want %h", k, PCPlus8, TP_PC8[k]); end
      end
      imem_ready = 1'b0;
   endtask

   task automatic test_stall();
      logic [31:0] want;
      int got;
      do_reset();
      imem_ready = 1'b1;
      tick();
      tick();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (InstrF !== 32'hA5A5A4A5 || PCPlus8 !== 32'h108 || validF !== 1'b1) begin
            errors++; $display("FAIL stall_hold[%0d]: got %h/%h/%b want a5a5a4a5/108/1", i, InstrF, PCPlus8, validF);
         end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle[%0d]: got %b want 0", i, imem_req); end
      end
      stall = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      got = 0;
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
         if (validF) begin
            want = exp_q.pop_front();
            got++;
            checks++; if (PCPlus8 !== want + 32'd8 || InstrF !== (want ^ KEY)) begin
               errors++; $display("FAIL stall_order[%0d]: got %h/%h want %h/%h", got, PCPlus8, InstrF, want + 32'd8, want ^ KEY);
            end
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d left want 0", exp_q.size()); end
      imem_ready = 1'b0;
   endtask

   task automatic test_ready_delay();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL wait_req[%0d]: got %b/%h want 1/100", i, imem_req, imem_addr);
         end
         checks++; if (validF !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d]: got %b want 0", i, validF); end
      end
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      checks++; if (validF !== 1'b1 || InstrF !== 32'hA5A5A4A5) begin
         errors++; $display("FAIL wait_resp: got %b/%h want 1/a5a5a4a5", validF, InstrF);
      end
      checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL wait_next: got %h want 104", imem_addr); end
   endtask

   task automatic test_redirect_drain();
      do_reset();
      imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (imem_addr !== 32'h10C) begin errors++; $display("FAIL rd_pre_addr: got %h want 10c", imem_addr); end
      imem_ready = 1'b0; redirect = 1'b1; BranchTarget = 32'h2000;
      tick();
      redirect = 1'b0;
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL rd_flush: got %b want 0", validF); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
         errors++; $display("FAIL rd_hold: got %b/%h want 1/10c", imem_req, imem_addr);
      end
      checks++; if (dbg_state !== ST_DRAIN) begin errors++; $display("FAIL rd_state: got %0d want 2", dbg_state); end
      tick();
      checks++; if (validF !== 1'b0 || imem_addr !== 32'h10C) begin
         errors++; $display("FAIL rd_hold2: got %b/%h want 0/10c", validF, imem_addr);
      end
      imem_ready = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || validF !== 1'b0) begin
         errors++; $display("FAIL rd_target: got %b/%h/%b want 1/2000/0", imem_req, imem_addr, validF);
      end
      tick();
      imem_ready = 1'b0;
      checks++; if (validF !== 1'b1 || InstrF !== 32'hA5A585A5 || PCPlus8 !== 32'h2008) begin
         errors++; $display("FAIL rd_word: got %b/%h/%h want 1/a5a585a5/2008", validF, InstrF, PCPlus8);
      end
   endtask

   task automatic test_redirect_stall_full();
      do_reset();
      imem_ready = 1'b1;
      tick();
      tick();
      stall = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b0 || validF !== 1'b1) begin
         errors++; $display("FAIL rs_full: got %b/%b want 0/1", imem_req, validF);
      end
      redirect = 1'b1; BranchTarget = 32'h3000;
      tick();
      redirect = 1'b0; stall = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
         errors++; $display("FAIL rs_addr: got %b/%h want 1/3000", imem_req, imem_addr);
      end
      checks++; if (validF !== 1'b0 || InstrF !== 32'h0) begin
         errors++; $display("FAIL rs_flush: got %b/%h want 0/0", validF, InstrF);
      end
      tick();
      imem_ready = 1'b0;
      checks++; if (InstrF !== 32'hA5A595A5 || PCPlus8 !== 32'h3008) begin
         errors++; $display("FAIL rs_word: got %h/%h want a5a595a5/3008", InstrF, PCPlus8);
      end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      redirect = 1'b1; BranchTarget = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_addr: got %b/%h want 1/fffffffc", imem_req, imem_addr);
      end
      imem_ready = 1'b1;
      tick();
      checks++; if (PCPlus8 !== 32'h4 || InstrF !== 32'h5A5A5A59) begin
         errors++; $display("FAIL wrap_pc8: got %h/%h want 4/5a5a5a59", PCPlus8, InstrF);
      end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 0", imem_addr); end
      reset = 1'b1; imem_ready = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b0 || validF !== 1'b0) begin
         errors++; $display("FAIL mid_rst_ctl: got %b/%b want 0/0", imem_req, validF);
      end
      checks++; if (InstrF !== 32'h0 || PCPlus8 !== 32'h0) begin
         errors++; $display("FAIL mid_rst_data: got %h/%h want 0/0", InstrF, PCPlus8);
      end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d want 0", dbg_state); end
      reset = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++; $display("FAIL post_rst: got %b/%h want 1/100", imem_req, imem_addr);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; BranchTarget = 32'h0; imem_ready = 1'b0;
      test_reset();
      test_throughput();
      test_stall();
      test_ready_delay();
      test_redirect_drain();
      test_redirect_stall_full();
      test_wrap_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
